// File: rtl/sound_queue.sv
`timescale 1ns/1ps
`default_nettype none
// sound_queue: prioritised 4-deep queue of game sound codes driving an active-low
// trigger to an external sound player, with per-sound play and inter-sound gap timing.
module sound_queue #(
    parameter int T_SHORT  = 1_000_000,
    parameter int T_LONG   = 2_500_000,
    parameter int TRIG_LEN = 4,
    parameter int GAP_LEN  = 250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_start,
    input  logic       ev_drop,
    input  logic       ev_error,
    input  logic       ev_victory,
    input  logic       mute,
    output logic       snd_start,
    output logic [1:0] snd_type,
    output logic       busy,
    output logic       dropped
);

    localparam int LEN_START = 4 * (T_LONG + 1) + 4;
    localparam int LEN_DROP  = 2 * (T_SHORT + 1) + 4;
    localparam int LEN_ERROR = 2 * (T_LONG + 1) + 4;
    localparam int LEN_VICT  = 13 * (T_LONG + 1) + 4;
    localparam int LEN_MAX_A = (LEN_VICT > LEN_DROP) ? LEN_VICT : LEN_DROP;
    localparam int LEN_MAX_B = (LEN_MAX_A > GAP_LEN) ? LEN_MAX_A : GAP_LEN;
    localparam int LEN_MAX   = (LEN_MAX_B > TRIG_LEN) ? LEN_MAX_B : TRIG_LEN;
    localparam int TW        = $clog2(LEN_MAX) + 1;

    localparam logic [1:0] CODE_START = 2'b00;
    localparam logic [1:0] CODE_DROP  = 2'b01;
    localparam logic [1:0] CODE_ERROR = 2'b10;
    localparam logic [1:0] CODE_VICT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   play_len;

    logic [1:0]      mem [4];
    logic [1:0]      rd_ptr;
    logic [1:0]      wr_ptr;
    logic [2:0]      count;

    logic            ev_any;
    logic            ev_multi;
    logic [2:0]      ev_num;
    logic [1:0]      ev_code;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop_now;

    // Event arbitration: only the most important event of a cycle survives.
    always_comb begin
        ev_num  = {2'b00, ev_start} + {2'b00, ev_drop} + {2'b00, ev_error} + {2'b00, ev_victory};
        ev_any  = (ev_num != 3'd0);
        ev_multi = (ev_num > 3'd1);
        ev_code = CODE_START;
        if (ev_victory) begin
            ev_code = CODE_VICT;
        end else if (ev_error) begin
            ev_code = CODE_ERROR;
        end else if (ev_drop) begin
            ev_code = CODE_DROP;
        end
    end

    always_comb begin
        fifo_full = (count == 3'd4);
        pop       = (state == ST_IDLE) && (count != 3'd0) && !mute;
        // A pop in the same cycle frees a slot, so a full queue can still accept.
        push      = ev_any && !ev_victory && (!fifo_full || pop);
        drop_now  = !mute && (ev_multi || (ev_any && !ev_victory && fifo_full && !pop));
    end

    always_comb begin
        play_len = TW'(LEN_START);
        case (snd_type)
            CODE_START: play_len = TW'(LEN_START);
            CODE_DROP:  play_len = TW'(LEN_DROP);
            CODE_ERROR: play_len = TW'(LEN_ERROR);
            CODE_VICT:  play_len = TW'(LEN_VICT);
            default:    play_len = TW'(LEN_START);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 2'b00;
            end
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (mute) begin
            rd_ptr <= wr_ptr;
            count  <= 3'd0;
        end else if (ev_victory) begin
            // Victory replaces whatever is pending; the flushed entries are not reported.
            mem[wr_ptr] <= CODE_VICT;
            rd_ptr      <= wr_ptr;
            wr_ptr      <= wr_ptr + 2'd1;
            count       <= 3'd1;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push) begin
                mem[wr_ptr] <= ev_code;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    // Timers count down and leave their state on the cycle they would reach zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            snd_start <= 1'b1;
            snd_type  <= CODE_START;
            busy      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            busy    <= (state != ST_IDLE) || (count != 3'd0);
            dropped <= drop_now;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        snd_type  <= mem[rd_ptr];
                        snd_start <= 1'b0;
                        timer     <= TW'(TRIG_LEN);
                        state     <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (timer <= TW'(1)) begin
                        snd_start <= 1'b1;
                        timer     <= play_len;
                        state     <= ST_PLAY;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_PLAY: begin
                    if (timer <= TW'(1)) begin
                        timer <= TW'(GAP_LEN);
                        state <= ST_GAP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (timer <= TW'(1)) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    timer     <= '0;
                    snd_start <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sound_queue.sv
`timescale 1ns/1ps
`default_nettype none
// tb_sound_queue: directed scenarios plus random events, every cycle compared against
// a timeline model of the queue (pop times, trigger window, busy-until edge).
module tb_sound_queue;

    localparam int T_SHORT  = 2;
    localparam int T_LONG   = 5;
    localparam int TRIG_LEN = 4;
    localparam int GAP_LEN  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_start = 1'b0;
    logic       ev_drop = 1'b0;
    logic       ev_error = 1'b0;
    logic       ev_victory = 1'b0;
    logic       mute = 1'b0;
    logic       snd_start;
    logic [1:0] snd_type;
    logic       busy;
    logic       dropped;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [1:0] q[$];
    int         ready_edge = 0;
    int         low_until  = 0;
    logic [1:0] type_m  = 2'b00;
    bit         busy_m  = 1'b0;
    bit         drop_m  = 1'b0;
    bit         start_m = 1'b1;

    sound_queue #(
        .T_SHORT  (T_SHORT),
        .T_LONG   (T_LONG),
        .TRIG_LEN (TRIG_LEN),
        .GAP_LEN  (GAP_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev_start   (ev_start),
        .ev_drop    (ev_drop),
        .ev_error   (ev_error),
        .ev_victory (ev_victory),
        .mute       (mute),
        .snd_start  (snd_start),
        .snd_type   (snd_type),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    function automatic int len_of(input logic [1:0] c);
        case (c)
            2'b00:   return 4 * (T_LONG + 1) + 4;
            2'b01:   return 2 * (T_SHORT + 1) + 4;
            2'b10:   return 2 * (T_LONG + 1) + 4;
            default: return 13 * (T_LONG + 1) + 4;
        endcase
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ready_edge = 0;
        low_until  = 0;
        type_m     = 2'b00;
        busy_m     = 1'b0;
        drop_m     = 1'b0;
        start_m    = 1'b1;
    endtask

    // One clock edge of the reference: a sound popped at edge p keeps the trigger low
    // for edges p..p+TRIG_LEN-1 and the player is free again at p+TRIG_LEN+len+GAP_LEN+1.
    task automatic model_edge();
        int         n;
        logic [1:0] code;
        busy_m = (cyc < ready_edge) || (q.size() != 0);
        if (!mute && q.size() > 0 && cyc >= ready_edge) begin
            type_m     = q.pop_front();
            low_until  = cyc + TRIG_LEN;
            ready_edge = cyc + TRIG_LEN + len_of(type_m) + GAP_LEN + 1;
        end
        drop_m = 1'b0;
        if (mute) begin
            q.delete();
        end else begin
            n = int'(ev_start) + int'(ev_drop) + int'(ev_error) + int'(ev_victory);
            code = ev_victory ? 2'b11 : ev_error ? 2'b10 : ev_drop ? 2'b01 : 2'b00;
            drop_m = (n > 1);
            if (ev_victory) begin
                q.delete();
                q.push_back(2'b11);
            end else if (n > 0) begin
                if (q.size() < 4) q.push_back(code);
                else drop_m = 1'b1;
            end
        end
        start_m = !(cyc < low_until);
    endtask

    task automatic step(input bit s, input bit d, input bit e, input bit v);
        ev_start   = s;
        ev_drop    = d;
        ev_error   = e;
        ev_victory = v;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        ev_start   = 1'b0;
        ev_drop    = 1'b0;
        ev_error   = 1'b0;
        ev_victory = 1'b0;
        check_eq("snd_start", snd_start, start_m);
        check_eq("snd_type", snd_type, type_m);
        check_eq("busy", busy, busy_m);
        check_eq("dropped", dropped, drop_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        check_eq("rst_snd_start", snd_start, 1);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(5);

        // Single drop: trigger low E+1..E+4, play 10, gap 3, busy falls at E+19.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (k <= 4) begin
                check_eq("drop_trig_low", snd_start, 0);
                check_eq("drop_type", snd_type, 1);
            end
            if (k == 5)  check_eq("drop_trig_high", snd_start, 1);
            if (k == 18) check_eq("drop_busy_e18", busy, 1);
            if (k == 19) check_eq("drop_busy_e19", busy, 0);
        end
        idle(5);

        // Drop and victory together: only victory queued, one dropped pulse.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("dual_dropped", dropped, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("dual_type", snd_type, 3);
        idle(120);

        // Five starts while the drop sound occupies the player: fifth is discarded.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check_eq("full_dropped", dropped, (i == 4) ? 1 : 0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(200);

        // Drop, then error and start while it plays: three triggers in order.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(120);

        // Three pending then victory: flushed, victory plays for its long length.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(150);

        // Mute mid-play with two pending: current sound finishes, queue cleared.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);
        mute = 1'b1;
        idle(30);
        check_eq("mute_busy", busy, 0);
        check_eq("mute_snd_start", snd_start, 1);
        mute = 1'b0;
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) mute = ~mute;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 119) == 0);
        end
        mute = 1'b0;
        idle(500);

        // Reset in the middle of a trigger with entries pending.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pre_rst_low", snd_start, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_start", snd_start, 1);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_type", snd_type, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sound_queue.md
SOUND_QUEUE -- requirements
Module: sound_queue

Interface
REQ-001 SHALL have parameter T_SHORT, default 1_000_000, cycles per short note, matching the 40 ms drop tone at 25 MHz.
REQ-002 SHALL have parameter T_LONG, default 2_500_000, cycles per long note, matching 100 ms at 25 MHz.
REQ-003 SHALL have parameter TRIG_LEN, default 4, number of cycles snd_start is held low; legal range 3..15.
REQ-004 SHALL have parameter GAP_LEN, default 250_000, silent cycles between queued sounds (10 ms).
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have ports ev_start, ev_drop, ev_error and ev_victory, each input, 1 bit, single-cycle game-event pulses.
REQ-008 SHALL have port mute, input, 1 bit, a level; high suppresses new sounds.
REQ-009 SHALL have port snd_start, output, 1 bit, active-low trigger to the sound player; idle high.
REQ-010 SHALL have port snd_type, output, 2 bits, sound code: 00 start, 01 drop, 10 error, 11 victory.
REQ-011 SHALL have port busy, output, 1 bit, high while sounding or while any entry is pending.
REQ-012 SHALL have port dropped, output, 1 bit, one-cycle pulse when an event is discarded.

Function
REQ-013 SHALL buffer sound codes in a 4-entry FIFO of 2-bit entries with 3-bit occupancy; all outputs SHALL be registered.
REQ-014 SHALL, when several events occur in one cycle, enqueue only the highest-priority one (victory > error > drop > start) and pulse dropped once for the rest.
REQ-015 SHALL, on a non-victory event with the FIFO full, discard the event and pulse dropped; a simultaneous pop SHALL free a slot so the event is accepted.
REQ-016 SHALL, on ev_victory, flush all pending entries, enqueue victory, and not pulse dropped for the flushed entries.
REQ-017 SHALL, while mute=1, discard every event without pulsing dropped and clear the FIFO.
REQ-018 SHALL NOT abort a sound already in TRIG or PLAY when mute rises.
REQ-019 SHALL have FSM IDLE: when the FIFO is non-empty and mute=0, pop the head into snd_type, drive snd_start=0 and go to TRIG.
REQ-020 SHALL have FSM TRIG: hold snd_start=0 for exactly TRIG_LEN cycles, then drive snd_start=1, load the play timer and go to PLAY.
REQ-021 SHALL load the play timer with n*(T+1)+4: start 4×(T_LONG+1), drop 2×(T_SHORT+1), error 2×(T_LONG+1), victory 13×(T_LONG+1), each plus 4 synchroniser margin.
REQ-022 SHALL have FSM PLAY: decrement the timer; at 0, load GAP_LEN and go to GAP.
REQ-023 SHALL have FSM GAP: decrement the timer; at 0, go to IDLE.
REQ-024 SHALL hold snd_type stable from the pop until the next pop.
REQ-025 SHALL size the timer width as $clog2 of the victory length plus 1; the timer SHALL never wrap.
REQ-026 SHALL make an event sampled at edge E visible in the FIFO at E and make snd_start fall at E+1 when the FSM is idle.
REQ-027 SHALL drive busy = (state≠IDLE) | (occupancy≠0).

Reset
REQ-028 SHALL, while rst_n=0, drive snd_start=1, snd_type=00, busy=0, dropped=0, empty the FIFO, zero the timer and hold IDLE, asynchronously.
REQ-029 SHALL, on reset asserted mid-TRIG, return snd_start high immediately; on release, not replay pre-reset entries.

Verification (T_SHORT=2, T_LONG=5, TRIG_LEN=4, GAP_LEN=3)
REQ-030 SHALL cover: ev_drop at edge E -> snd_type=01 and snd_start=0 over E+1..E+4, snd_start=1 at E+5, PLAY 10 cycles, GAP 3 cycles, busy low at E+19.
REQ-031 SHALL cover: ev_drop, then ev_error and ev_start while playing -> three triggers in order 01, 10, 00, each separated by a 3-cycle gap.
REQ-032 SHALL cover: 5 ev_start pulses in one busy period with FIFO full -> dropped pulses once on the 5th; 4 sounds play.
REQ-033 SHALL cover: ev_drop and ev_victory in the same cycle -> only victory (11) is queued and dropped pulses once.
REQ-034 SHALL cover: 3 entries pending, then ev_victory -> flushed; the next trigger is snd_type=11 with play length 13×6+4=82 cycles.
REQ-035 SHALL cover: mute=1 mid-PLAY with 2 pending -> the current sound completes, the FIFO clears, no further snd_start fall, and busy falls after the gap.
